// File: rtl/axis_sched_in_arb.sv
// -----------------------------------------------------------------------------
// axis_sched_in_arb
//
// N:1 AXI-Stream funnel in front of the scheduler input queue. A slave that
// wins arbitration keeps the grant until its tlast beat has been accepted,
// so packets are never interleaved. The winner is picked round-robin
// (starting at the slave after the last one served). Beats go through a
// 2-entry skid buffer so every master-side output comes straight from a flop,
// and each beat carries the index of the slave it came from on m_src.
//
// Build option:
//   AXIS_SCHED_IN_ARB_PRIO_EN  defined   -> fixed priority, lowest valid index
//                                           wins; no round-robin pointer.
//                              undefined -> round-robin (default).
//
// Parameters:
//   NSLAVES    number of slave inputs (1..16)
//   DATA_WIDTH tdata width
//   ID_WIDTH   tid width (>= 1)
//   SRC_WIDTH  derived width of m_src, max(1, $clog2(NSLAVES))
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   s_valid/s_ready   per-slave handshake, one bit per slave
//   s_data, s_id      packed slave buses, slave k at [k*W +: W]
//   s_last            per-slave tlast
//   m_valid/m_ready   master handshake
//   m_data/m_id/m_last master beat
//   m_src             slave index that produced the current master beat
// -----------------------------------------------------------------------------
module axis_sched_in_arb #(
  parameter  int NSLAVES    = 2,
  parameter  int DATA_WIDTH = 64,
  parameter  int ID_WIDTH   = 8,
  localparam int SRC_WIDTH  = (NSLAVES > 1) ? $clog2(NSLAVES) : 1
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NSLAVES-1:0]            s_valid,
  output logic [NSLAVES-1:0]            s_ready,
  input  logic [NSLAVES*DATA_WIDTH-1:0] s_data,
  input  logic [NSLAVES*ID_WIDTH-1:0]   s_id,
  input  logic [NSLAVES-1:0]            s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [ID_WIDTH-1:0]           m_id,
  output logic                          m_last,
  output logic [SRC_WIDTH-1:0]          m_src
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic                  last;
    logic [SRC_WIDTH-1:0]  src;
  } beat_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SRC_WIDTH-1:0] r_grant;
  logic [SRC_WIDTH-1:0] w_grant_nxt;
  logic [SRC_WIDTH-1:0] w_pick;
  logic                 w_found;
  logic                 w_sel_valid;
  beat_t                w_in;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  beat_t                r_buf0;     // head entry, drives m_*
  beat_t                r_buf1;     // second entry, only used under stall
  logic [1:0]           r_count;

`ifndef AXIS_SCHED_IN_ARB_PRIO_EN
  logic [SRC_WIDTH-1:0] r_rr_ptr;
  logic [SRC_WIDTH-1:0] w_rr_nxt;
`endif

  // ---------------------------------------------------------------------------
  // Arbiter. Round-robin is done as two constant-index scans: first the
  // slaves at or above the pointer, then (if nobody was found) from slave 0,
  // which gives the wrap-around without any modulo arithmetic.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default on the first
  // lines of the block; a path that leaves it unassigned would infer a latch.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
`ifndef AXIS_SCHED_IN_ARB_PRIO_EN
    for (int i = 0; i < NSLAVES; i++) begin
      if (!w_found && s_valid[i] && (SRC_WIDTH'(i) >= r_rr_ptr)) begin
        w_pick  = SRC_WIDTH'(i);
        w_found = 1'b1;
      end
    end
`endif
    for (int i = 0; i < NSLAVES; i++) begin
      if (!w_found && s_valid[i]) begin
        w_pick  = SRC_WIDTH'(i);
        w_found = 1'b1;
      end
    end
  end

  // Granted-slave mux; the source index rides along with the beat.
  always_comb begin
    w_in        = '0;
    w_sel_valid = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (r_grant == SRC_WIDTH'(i)) begin
        w_sel_valid = s_valid[i];
        w_in.data   = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_in.id     = s_id[i*ID_WIDTH +: ID_WIDTH];
        w_in.last   = s_last[i];
      end
    end
    w_in.src = r_grant;
  end

  assign w_full = (r_count == 2'd2);
  assign w_push = (r_state == ST_LOCKED) && w_sel_valid && !w_full;
  assign w_pop  = m_valid && m_ready;

  // Only the locked slave sees ready, and only while the buffer has room.
  always_comb begin
    s_ready = '0;
    if ((r_state == ST_LOCKED) && !w_full) begin
      for (int i = 0; i < NSLAVES; i++) begin
        if (r_grant == SRC_WIDTH'(i)) s_ready[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packet lock FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
`ifndef AXIS_SCHED_IN_ARB_PRIO_EN
    w_rr_nxt    = r_rr_ptr;
`endif
    case (r_state)
      ST_IDLE: begin
        if (|s_valid) begin
          w_state_nxt = ST_LOCKED;
          w_grant_nxt = w_pick;
        end
      end
      ST_LOCKED: begin
        if (w_push && w_in.last) begin
          w_state_nxt = ST_IDLE;
`ifndef AXIS_SCHED_IN_ARB_PRIO_EN
          w_rr_nxt    = (r_grant == SRC_WIDTH'(NSLAVES - 1)) ? '0 : r_grant + 1'b1;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
`ifndef AXIS_SCHED_IN_ARB_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
`ifndef AXIS_SCHED_IN_ARB_PRIO_EN
      r_rr_ptr <= w_rr_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry skid buffer, head always in r_buf0. Push+pop with one entry held
  // replaces the head in place; push+pop while full cannot happen because
  // s_ready is low then.
  // ---------------------------------------------------------------------------
  // NOTE: the storage entries are reset as well because they drive m_* directly
  // and those outputs must read zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf0  <= '0;
      r_buf1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_buf0 <= w_in;
          else                 r_buf1 <= w_in;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_buf0  <= r_buf1;
          r_count <= r_count - 2'd1;
        end
        2'b11: r_buf0 <= w_in;
        default: ;
      endcase
    end
  end

  assign m_valid = (r_count != 2'd0);
  assign m_data  = r_buf0.data;
  assign m_id    = r_buf0.id;
  assign m_last  = r_buf0.last;
  assign m_src   = r_buf0.src;

endmodule

// File: tb/tb_axis_sched_in_arb.sv
// -----------------------------------------------------------------------------
// tb_axis_sched_in_arb
//
// Bench for axis_sched_in_arb with NSLAVES=4. A table of arbitration records
// (which slaves send how many packets, start delays, expected grant order)
// is applied in a loop; hand-written sequences cover reset/latency,
// backpressure, a long random run and reset in the middle of a packet.
// Master beats are checked against per-slave expected queues, m_src must not
// change inside a packet, and m_* must hold while stalled.
// -----------------------------------------------------------------------------
module tb_axis_sched_in_arb;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int IW = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [NS-1:0]    s_valid;
  logic [NS-1:0]    s_ready;
  logic [NS*DW-1:0] s_data;
  logic [NS*IW-1:0] s_id;
  logic [NS-1:0]    s_last;
  logic             m_valid;
  logic             m_ready;
  logic [DW-1:0]    m_data;
  logic [IW-1:0]    m_id;
  logic             m_last;
  logic [1:0]       m_src;

  axis_sched_in_arb #(.NSLAVES(NS), .DATA_WIDTH(DW), .ID_WIDTH(IW)) u_dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_id(s_id), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id), .m_last(m_last),
    .m_src(m_src)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          last;
  } beat_t;

  typedef struct {
    logic [3:0]      mask;    // slaves taking part
    int              npkts;   // packets per participating slave
    int              nbeats;  // beats per packet
    logic [0:3][3:0] dly;     // start delay in cycles, per slave
    logic [0:7][1:0] ord;     // expected m_src of each packet, first at [0]
    int              nord;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          seq   = 0;
  int          m_beats = 0;
  beat_t       tx_q  [NS][$];
  beat_t       exp_q [NS][$];
  logic [1:0]  order_q[$];
  int          delay_c[NS];
  vec_t        vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_packet(input int k, input int nb);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data = {8'(k), 8'h5A, 32'(seq), 16'(i)};
      b.id   = 8'(k * 16 + (i % 16));
      b.last = (i == nb - 1);
      seq++;
      tx_q[k].push_back(b);
      exp_q[k].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NS; k++)
      if (tx_q[k].size() != 0 || exp_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Drives all slaves from tx_q and the master ready, checks every master
  // beat. Entered and left at posedge+1.
  task automatic run_scenario(input int gap_pct, input int ready_pct, input bit chk_order,
                              input int stall_at, input int stall_len, input int max_cyc);
    bit         hold[NS];
    bit         m_hold = 1'b0;
    bit         in_stall;
    logic [74:0] held = '0;
    logic [74:0] cur;
    logic       in_pkt = 1'b0;
    logic [1:0] cur_src = 2'd0;
    logic [1:0] eo;
    beat_t      e;
    int         stall_acc = 0;
    int         cyc = 0;
    bit         done = 1'b0;
    for (int k = 0; k < NS; k++) hold[k] = 1'b0;
    while (!done && cyc < max_cyc) begin
      for (int k = 0; k < NS; k++) begin
        if (!hold[k]) begin
          if (tx_q[k].size() != 0 && cyc >= delay_c[k] && int'($urandom_range(99)) >= gap_pct) begin
            s_valid[k]         = 1'b1;
            s_data[k*DW +: DW] = tx_q[k][0].data;
            s_id[k*IW +: IW]   = tx_q[k][0].id;
            s_last[k]          = tx_q[k][0].last;
            hold[k]            = 1'b1;
          end else begin
            s_valid[k] = 1'b0;
          end
        end
      end
      in_stall = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
      m_ready  = in_stall ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
      @(negedge clk);
      cur = {m_data, m_id, m_last, m_src};
      if (m_hold) check("m_stable", {m_valid, cur}, {1'b1, held});
      if (m_valid && m_ready) begin
        m_beats++;
        if (in_pkt) begin
          check("m_src_lock", m_src, cur_src);
        end else if (chk_order) begin
          if (order_q.size() == 0) check("grant_order_extra", 1, 0);
          else begin
            eo = order_q.pop_front();
            check("grant_order", m_src, eo);
          end
        end
        if (exp_q[m_src].size() == 0) check("m_unexpected", 1, 0);
        else begin
          e = exp_q[m_src].pop_front();
          check("m_beat", {m_data, m_id, m_last}, {e.data, e.id, e.last});
        end
        in_pkt  = !m_last;
        cur_src = m_src;
      end
      m_hold = m_valid && !m_ready;
      held   = cur;
      for (int k = 0; k < NS; k++) begin
        if (s_valid[k] && s_ready[k]) begin
          void'(tx_q[k].pop_front());
          hold[k] = 1'b0;
          if (in_stall) stall_acc++;
        end
      end
      if (stall_len > 0 && cyc == stall_at + stall_len - 1) begin
        check("stall_accepts_le2", (stall_acc <= 2), 1);
        check("stall_s_ready", s_ready, 4'b0000);
      end
      @(posedge clk); #1;
      cyc++;
      done = all_empty();
    end
    if (!done) check("scenario_timeout", 0, 1);
    if (chk_order) check("order_consumed", order_q.size(), 0);
    s_valid = '0;
    m_ready = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic [3:0] mask, input int npkts, input int nbeats,
                         input logic [0:3][3:0] dly, input logic [0:7][1:0] ord, input int nord);
    vecs[i].mask   = mask;
    vecs[i].npkts  = npkts;
    vecs[i].nbeats = nbeats;
    vecs[i].dly    = dly;
    vecs[i].ord    = ord;
    vecs[i].nord   = nord;
  endtask

  task automatic apply_vec(input vec_t v);
    for (int k = 0; k < NS; k++) delay_c[k] = int'(v.dly[k]);
    for (int p = 0; p < v.npkts; p++)
      for (int k = 0; k < NS; k++)
        if (v.mask[k]) add_packet(k, v.nbeats);
    for (int i = 0; i < v.nord; i++) order_q.push_back(v.ord[i]);
    run_scenario(0, 100, 1'b1, 0, 0, 2000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int total;
    int k;
    int nb;

    // Grant order comments assume the round-robin pointer carried over from
    // the previous record (it is 3 after the reset/single-beat sequence).
    // {1,1,1,...} fields list the expected m_src of each packet in order.
`ifdef AXIS_SCHED_IN_ARB_PRIO_EN
    set_vec(0, 4'b1000, 1, 1, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1);
    set_vec(1, 4'b1111, 2, 2, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3}, 8);
    set_vec(2, 4'b0011, 1, 4, {4'd0, 4'd3, 4'd0, 4'd0}, {2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 2);
    set_vec(3, 4'b1010, 1, 1, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 2);
    set_vec(4, 4'b0101, 1, 1, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 2);
    set_vec(5, 4'b1010, 3, 1, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0}, 6);
`else
    set_vec(0, 4'b1000, 1, 1, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1);
    set_vec(1, 4'b1111, 2, 2, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3}, 8);
    set_vec(2, 4'b0011, 1, 4, {4'd0, 4'd3, 4'd0, 4'd0}, {2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 2);
    set_vec(3, 4'b1010, 1, 1, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 2);
    set_vec(4, 4'b0101, 1, 1, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 2);
    set_vec(5, 4'b1010, 3, 1, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0, 2'd0}, 6);
`endif
    set_vec(6, 4'b0100, 1, 1, {4'd0, 4'd0, 4'd0, 4'd0}, {2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, 1);

    // ---- reset state and single-beat latency ----
    rstn    = 1'b0;
    s_valid = '0;
    s_data  = '0;
    s_id    = '0;
    s_last  = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 4'b0000);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_fields", {m_data, m_id, m_last, m_src}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    s_valid[2]        = 1'b1;
    s_data[2*DW +: DW] = 64'hA5;
    s_id[2*IW +: IW]   = 8'd3;
    s_last[2]         = 1'b1;
    m_ready           = 1'b1;
    @(negedge clk);
    check("idle_s_ready", s_ready, 4'b0000);
    check("lat_c0_m_valid", m_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("locked_s_ready", s_ready, 4'b0100);
    check("lat_c1_m_valid", m_valid, 0);
    @(posedge clk); #1;
    s_valid = '0;
    @(negedge clk);
    check("lat_c2_beat", {m_valid, m_data, m_id, m_last, m_src}, {1'b1, 64'hA5, 8'd3, 1'b1, 2'd2});
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_c3_m_valid", m_valid, 0);
    @(posedge clk); #1;

    // ---- table of arbitration records ----
    for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

    // ---- backpressure: 8-beat packet, m_ready low for 5 cycles ----
    for (int j = 0; j < NS; j++) delay_c[j] = 0;
    add_packet(0, 8);
    order_q.push_back(2'd0);
    run_scenario(0, 100, 1'b1, 4, 5, 500);

    // ---- random run: 1000 beats, gaps and random ready ----
    total   = 0;
    m_beats = 0;
    while (total < 1000) begin
      k  = int'($urandom_range(3));
      nb = int'($urandom_range(6, 1));
      if (nb > 1000 - total) nb = 1000 - total;
      add_packet(k, nb);
      total += nb;
    end
    run_scenario(30, 70, 1'b0, 0, 0, 20000);
    check("random_beat_count", m_beats, 1000);

    // ---- leave the pointer at 3, then reset during beat 2 of 3 ----
    apply_vec(vecs[6]);
    s_valid[3]         = 1'b1;
    s_data[3*DW +: DW] = 64'h3333_0000_0000_0000;
    s_id[3*IW +: IW]   = 8'h30;
    s_last[3]          = 1'b0;
    m_ready            = 1'b1;
    w = 0;
    @(negedge clk);
    while (!s_ready[3] && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("midrst_grant", s_ready[3], 1);
    @(posedge clk); #1;
    s_data[3*DW +: DW] = 64'h3333_0000_0000_0001;
    @(negedge clk);
    check("midrst_m_valid_before", m_valid, 1);
    rstn = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 4'b0000);
    s_valid = '0;
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    // Pointer back at 0: slave 1 must win over slave 3.
    add_packet(1, 1);
    add_packet(3, 1);
    order_q.push_back(2'd1);
    order_q.push_back(2'd3);
    run_scenario(0, 100, 1'b1, 0, 0, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
